// File: rtl/rx_cp_remover_frame.sv
// rx_cp_remover_frame: receive-side cyclic-prefix remover with frame SOP, signed timing offset,
// long first-symbol CP, deferred re-synchronisation and per-frame symbol indexing.
// Ports:
//   clk, rst (async active-low)
//   iv, isop, in_real_data, in_imag_data, delay_sop : gapped input stream, frame SOP and signed offset
//   oval, osop, oeop, out_real_data, out_imag_data : useful samples with symbol framing, one cycle later
//   symb_idx, frame_done, resync, busy             : symbol index and frame status
module rx_cp_remover_frame #(
    parameter int DATA_W   = 12,
    parameter int FFT_SIZE = 1024,
    parameter int CP_LEN   = 32,
    parameter int CP_FIRST = 32,
    parameter int N_SYMB   = 50,
    parameter int OFS_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iv,
    input  logic                      isop,
    input  logic [DATA_W-1:0]         in_real_data,
    input  logic [DATA_W-1:0]         in_imag_data,
    input  logic [OFS_W-1:0]          delay_sop,
    output logic                      oval,
    output logic                      osop,
    output logic                      oeop,
    output logic [DATA_W-1:0]         out_real_data,
    output logic [DATA_W-1:0]         out_imag_data,
    output logic [$clog2(N_SYMB)-1:0] symb_idx,
    output logic                      frame_done,
    output logic                      resync,
    output logic                      busy
);
    localparam int SW = $clog2(N_SYMB);
    localparam int PW = $clog2(CP_FIRST + FFT_SIZE + 2 ** (OFS_W - 1)) + 2;
    localparam logic signed [PW-1:0] CPF  = PW'(CP_FIRST);
    localparam logic signed [PW-1:0] CPL  = PW'(CP_LEN);
    localparam logic signed [PW-1:0] ENDF = PW'(CP_FIRST + FFT_SIZE - 1);
    localparam logic signed [PW-1:0] ENDL = PW'(CP_LEN + FFT_SIZE - 1);
    localparam logic signed [PW-1:0] ONE  = PW'(1);
    localparam logic [SW-1:0]        LAST = SW'(N_SYMB - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_n;
    logic signed [PW-1:0]  pos, pos_n, lat, lat_n, ofs_ext, eff_pos, cpl, cpl_end;
    logic [SW-1:0]         cnt, cnt_n, eff_cnt;
    logic                  pend, pend_n, run, sop, fwd, first, last, done, rsy;

    assign ofs_ext = PW'(signed'(delay_sop));
    assign busy    = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // The SOP sample in IDLE is evaluated at pos = delay_sop; in RUN the register holds
    // the position of the next valid sample.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = cnt;
        pend_n  = pend;
        lat_n   = lat;
        run     = (state == RUN);
        sop     = iv & isop;
        eff_pos = run ? pos : ofs_ext;
        eff_cnt = run ? cnt : '0;
        cpl     = (eff_cnt == '0) ? CPF : CPL;
        cpl_end = (eff_cnt == '0) ? ENDF : ENDL;
        fwd     = iv & (run | isop) & (eff_pos >= cpl);
        first   = (eff_pos == cpl);
        last    = run & (eff_pos == cpl_end);
        done    = iv & last & ~sop & ~pend & (cnt == LAST);
        rsy     = iv & last & ~sop & pend;
        if (iv) begin
            if (sop & (~run | last)) begin
                state_n = RUN;
                pos_n   = ofs_ext + ONE;
                cnt_n   = '0;
                pend_n  = 1'b0;
            end else if (last) begin
                pos_n   = pend ? lat : '0;
                cnt_n   = (pend | (cnt == LAST)) ? '0 : cnt + SW'(1);
                pend_n  = 1'b0;
                state_n = done ? IDLE : RUN;
            end else if (run) begin
                pos_n  = pos + ONE;
                pend_n = pend | sop;
                lat_n  = sop ? ofs_ext : lat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos           <= '0;
            cnt           <= '0;
            pend          <= 1'b0;
            lat           <= '0;
            oval          <= 1'b0;
            osop          <= 1'b0;
            oeop          <= 1'b0;
            out_real_data <= '0;
            out_imag_data <= '0;
            symb_idx      <= '0;
            frame_done    <= 1'b0;
            resync        <= 1'b0;
        end else begin
            pos           <= pos_n;
            cnt           <= cnt_n;
            pend          <= pend_n;
            lat           <= lat_n;
            oval          <= fwd;
            osop          <= fwd & first;
            oeop          <= fwd & last;
            out_real_data <= fwd ? in_real_data : '0;
            out_imag_data <= fwd ? in_imag_data : '0;
            symb_idx      <= fwd ? eff_cnt : (run ? symb_idx : '0);
            frame_done    <= done;
            resync        <= rsy;
        end
    end
endmodule

// File: tb/tb_rx_cp_remover_frame.sv
// tb_rx_cp_remover_frame: directed bench for rx_cp_remover_frame with FFT_SIZE=16, CP_LEN=4, CP_FIRST=8, N_SYMB=3.
module tb_rx_cp_remover_frame;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iv = 1'b0, isop = 1'b0;
    logic [11:0] in_real_data = '0, in_imag_data = '0;
    logic [5:0]  delay_sop = '0;
    logic        oval, osop, oeop, frame_done, resync, busy;
    logic [11:0] out_real_data, out_imag_data;
    logic [1:0]  symb_idx;

    typedef struct packed {
        logic [11:0] d;
        logic [11:0] m;
        logic        s, e;
        logic [1:0]  i;
        logic        f, r;
    } rec_t;

    rec_t q[$];
    int   n_chk = 0, n_pass = 0, fd = 0, rs = 0, gap_err = 0;

    rx_cp_remover_frame #(
        .DATA_W(12), .FFT_SIZE(16), .CP_LEN(4), .CP_FIRST(8), .N_SYMB(3), .OFS_W(6)
    ) dut (
        .clk(clk), .rst(rst), .iv(iv), .isop(isop),
        .in_real_data(in_real_data), .in_imag_data(in_imag_data), .delay_sop(delay_sop),
        .oval(oval), .osop(osop), .oeop(oeop),
        .out_real_data(out_real_data), .out_imag_data(out_imag_data),
        .symb_idx(symb_idx), .frame_done(frame_done), .resync(resync), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic v, input logic s, input int k, input int ofs);
        iv           = v;
        isop         = s;
        in_real_data = 12'(k);
        in_imag_data = 12'(3 * k);
        delay_sop    = 6'(ofs);
        @(posedge clk);
        #1;
        if (oval) q.push_back('{out_real_data, out_imag_data, osop, oeop, symb_idx, frame_done, resync});
        if (frame_done) fd++;
        if (resync) rs++;
        if (oval && !v) gap_err++;
    endtask

    task automatic run(input int n, input int gap, input int s0, input int o0,
                       input int s1, input int o1, input int s2, input int o2);
        int k;
        logic v;
        q.delete();
        fd = 0; rs = 0; gap_err = 0; k = 0;
        for (int c = 0; k < n; c++) begin
            v = gap ? (c % 2 == 0) : 1'b1;
            step(v, v && (k == s0 || k == s1 || k == s2), k, (k == s1) ? o1 : (k == s2) ? o2 : o0);
            if (v) k++;
        end
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic grp(input string tag, input int b, input int s0, input int idx);
        int ok;
        if (b + 16 > q.size()) begin
            check({tag, " size"}, q.size(), b + 16);
            return;
        end
        ok = 1;
        for (int j = 0; j < 16; j++)
            if (q[b+j].d != 12'(s0 + j) || q[b+j].m != 12'(3 * (s0 + j)) || q[b+j].i != 2'(idx) ||
                q[b+j].s != (j == 0) || q[b+j].e != (j == 15)) ok = 0;
        check({tag, " first"}, int'(q[b].d), s0);
        check({tag, " body"}, ok, 1);
    endtask

    initial begin
        #12;
        check("reset oval", int'(oval), 0);
        check("reset data", int'(out_real_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset idx", int'(symb_idx), 0);
        @(negedge clk);
        rst = 1'b1;

        run(70, 0, 0, 0, -1, 0, -1, 0);
        check("cont count", q.size(), 48);
        grp("cont s0", 0, 8, 0);
        grp("cont s1", 16, 28, 1);
        grp("cont s2", 32, 48, 2);
        if (q.size() == 48) check("cont fd on last", int'(q[47].f), 1);
        check("cont fd pulses", fd, 1);
        check("cont rs pulses", rs, 0);
        check("cont idle", int'(busy), 0);

        run(70, 0, 0, 3, -1, 0, -1, 0);
        check("ofs+3 count", q.size(), 48);
        grp("ofs+3 s0", 0, 5, 0);
        grp("ofs+3 s1", 16, 25, 1);

        run(70, 0, 0, -2, -1, 0, -1, 0);
        check("ofs-2 count", q.size(), 48);
        grp("ofs-2 s0", 0, 10, 0);
        grp("ofs-2 s1", 16, 30, 1);

        run(70, 1, 0, 0, -1, 0, -1, 0);
        check("gap count", q.size(), 48);
        grp("gap s0", 0, 8, 0);
        grp("gap s2", 32, 48, 2);
        check("gap mirror", gap_err, 0);
        check("gap fd pulses", fd, 1);

        run(90, 0, 0, 0, 12, 5, 14, 1);
        check("mid count", q.size(), 64);
        grp("mid s0", 0, 8, 0);
        grp("mid new s0", 16, 31, 0);
        grp("mid new s1", 32, 51, 1);
        if (q.size() >= 16) check("mid rs on eop", int'(q[15].r), 1);
        if (q.size() >= 16) check("mid no fd on eop", int'(q[15].f), 0);
        check("mid rs pulses", rs, 1);
        check("mid fd pulses", fd, 1);

        run(90, 0, 0, 0, 23, 0, -1, 0);
        check("bnd count", q.size(), 64);
        grp("bnd s0", 0, 8, 0);
        grp("bnd new s0", 16, 31, 0);
        grp("bnd new s2", 48, 71, 2);
        check("bnd rs pulses", rs, 0);
        if (q.size() == 64) check("bnd fd on last", int'(q[63].f), 1);

        q.delete();
        step(1'b1, 1'b1, 0, 0);
        for (int k = 1; k < 15; k++) step(1'b1, 1'b0, k, 0);
        check("rst pre oval", int'(oval), 1);
        check("rst pre busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("rst async oval", int'(oval), 0);
        check("rst async data", int'(out_real_data), 0);
        check("rst async busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        run(40, 0, -1, 0, -1, 0, -1, 0);
        check("rst no output", q.size(), 0);
        check("rst no eop", fd + rs, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/rx_cp_remover_frame.md
# rx_cp_remover_frame

Parametrised receive-side cyclic-prefix remover for the OFDM modem RX chain, sitting between the timing-sync/SOP detector and the FFT input interlayer. It accepts a gapped sample stream with a frame SOP, discards the cyclic prefix of each symbol, and forwards exactly `FFT_SIZE` samples per symbol with symbol SOP/EOP framing. Compared with the fixed-CP, continuous-stream layer it replaces, it adds:

- input valid gating
- a distinct first-symbol (long) CP
- a signed fine-timing offset
- deferred re-synchronisation on a mid-symbol SOP
- symbol indexing and frame-completion status

## Interface

- `DATA_W`, 12, I and Q sample width.
- `FFT_SIZE`, 1024, useful samples per symbol; power of two.
- `CP_LEN`, 32, CP length of symbols 1..N_SYMB-1.
- `CP_FIRST`, 32, CP length of symbol 0 of each frame; must be ≥ `CP_LEN`.
- `N_SYMB`, 50, symbols per frame.
- `OFS_W`, 6, width of signed timing offset.

Ports:

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `iv` in 1: input sample valid.
- `isop` in 1: frame start marker; qualified by `iv`.
- `in_real_data` in `DATA_W`: I sample.
- `in_imag_data` in `DATA_W`: Q sample.
- `delay_sop` in `OFS_W`, signed: timing offset; sampled on an accepted SOP.
- `oval` out 1: output sample valid.
- `osop` out 1: first useful sample of a symbol.
- `oeop` out 1: last useful sample of a symbol.
- `out_real_data` out `DATA_W`: I output; zero when `oval`=0.
- `out_imag_data` out `DATA_W`: Q output; zero when `oval`=0.
- `symb_idx` out `$clog2(N_SYMB)`: index of the symbol being output.
- `frame_done` out 1: one-cycle pulse after the last sample of symbol N_SYMB-1.
- `resync` out 1: one-cycle pulse when a deferred SOP is applied.
- `busy` out 1: frame in progress.

## Operation

- **Sample position counter `pos`.** Signed, wide enough for `CP_FIRST+FFT_SIZE+2^(OFS_W-1)`. Advances only on `iv`=1.
- **Current CP length `cpl`.** Equals `CP_FIRST` when the symbol count is 0, otherwise `CP_LEN`. The symbol ends at `pos` = `cpl+FFT_SIZE-1`.
- **FSM states:**
  - IDLE: `busy`=0. An accepted SOP loads `pos`=`delay_sop` for the SOP sample itself, sets symbol count 0, and goes to RUN.
  - RUN: a sample with `cpl` ≤ `pos` ≤ `cpl+FFT_SIZE-1` is forwarded.
    - `osop` is set at `pos`=`cpl`.
    - `oeop` is set at `pos`=`cpl+FFT_SIZE-1`.
    - Samples with `pos` < `cpl` (including negative `pos`) are discarded.
  - At end of symbol: if the symbol count is N_SYMB-1, pulse `frame_done` and go to IDLE. Otherwise increment the symbol count and set `pos`=0 for the next valid sample.
- **Offset behaviour.**
  - Positive `delay_sop` shortens the discarded prefix of symbol 0 only.
  - Negative `delay_sop` lengthens it.
  - Later symbols start at `pos`=0.
- **SOP at a boundary.** An accepted SOP in IDLE, or on the same sample as an end of symbol, restarts the frame immediately. The SOP sample gets `pos`=`delay_sop` and symbol count 0; `frame_done` is suppressed in this case.
- **SOP mid-symbol.** An accepted SOP while in RUN and not at a symbol end sets `pend` and latches `delay_sop`.
  - The current symbol completes normally.
  - At its end, the frame restarts with the latched offset: the next valid sample gets `pos`=latched offset, symbol count returns to 0, and `resync` pulses. No `frame_done` is generated.
  - A second SOP while `pend` is set overwrites the latched offset.
- **Output symbol index.** `symb_idx` holds the index of the symbol being output; it is 0 in IDLE.
- **Ignored inputs.** `isop` with `iv`=0 is ignored.

## Timing

- **Reset values.** All outputs are 0 on reset; state is IDLE, `pend`=0, `pos`=0. Reset is asynchronous, and its deassertion is synchronous to `clk`.
- **Latency.** One cycle, registered. A sample accepted at cycle t appears at t+1 with `oval`/`osop`/`oeop`/`symb_idx`.
- **Status pulse timing.** `frame_done` and `resync` are asserted in the same cycle as the `oeop` of the symbol that triggered them.
- **Output gaps.** Input gaps (`iv`=0) produce output gaps; there is no buffering and no backpressure.
- **Throughput.** One sample per clock sustained.
- **`osop` and `oeop` together.** They are never coincident, since `FFT_SIZE` > 1.
- **Reset mid-frame.** The current frame is aborted and no partial `oeop` is generated.

## Test plan

Bench override for all scenarios: `FFT_SIZE`=16, `CP_LEN`=4, `CP_FIRST`=8, `N_SYMB`=3. Input data is a ramp.

- **Continuous frame.** `iv`=1 continuous, SOP at sample 0, `delay_sop`=0 -> samples 8..23, 28..43 and 48..63 are output (48 `oval`). `osop` on the first and `oeop` on the last of each group, `symb_idx` 0/1/2, `frame_done` with the last `oeop`, then IDLE.
- **Signed offset.** `delay_sop`=+3 -> first output is input sample 5; `delay_sop`=-2 -> first output is sample 10. Symbol 1 output is unchanged relative to the symbol-0 end.
- **Gapped input.** `iv` toggling 1,0 -> the same 48 samples are output with the same values and gaps mirrored one cycle later.
- **Mid-symbol SOP.** SOP at sample 12, `delay_sop`=1 -> symbol 0 completes (samples 8..23). `resync` pulses with that `oeop`, and the next symbol is index 0 with its first output at sample 31; no `frame_done`.
- **Boundary SOP.** SOP on sample 23 (the symbol-0 end) -> immediate restart; sample 23 has `pos`=0, the next output is samples 31..46 with `symb_idx`=0, and neither `resync` nor `frame_done` pulses.
- **Reset mid-frame.** Assert `rst`=0 at sample 15 -> all outputs go to 0 asynchronously; after release without a SOP, no output appears.
